// File: rtl/volatility_arbiter.sv
// volatility_arbiter: round-robin front end for a shared volatility datapath.
// Holds a per-stock in-flight lock, the per-stock buffer-size/reciprocal table,
// and a tag FIFO that names the stock of each returning result.
// Optional build macro: VOL_ARB_STATS_EN enables the stall-cycle counter.
module volatility_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int NUM_STOCKS   = 4,
   parameter int DATA_WIDTH   = 32,
   parameter int FP_WORD_SIZE = 64,
   parameter logic [DATA_WIDTH-1:0]   DEFAULT_BSIZE = DATA_WIDTH'(32),
   parameter logic [FP_WORD_SIZE-1:0] DEFAULT_RECIP = FP_WORD_SIZE'(64'h0000_0000_0800_0000),
   localparam int SID_W = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1
) (
   input  logic                          i_clk,
   input  logic                          i_reset,
   input  logic [NUM_REQ-1:0]            i_req_valid,
   output logic [NUM_REQ-1:0]            o_req_ready,
   input  logic [NUM_REQ*SID_W-1:0]      i_req_stock_id,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_best_ask,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_best_bid,
   input  logic                          i_cfg_wr_en,
   output logic                          o_cfg_ready,
   input  logic [SID_W-1:0]              i_cfg_stock_id,
   input  logic [DATA_WIDTH-1:0]         i_cfg_buffer_size,
   input  logic [FP_WORD_SIZE-1:0]       i_cfg_recip,
   output logic [SID_W-1:0]              o_stock_id,
   output logic                          o_data_valid,
   output logic [DATA_WIDTH-1:0]         o_best_ask,
   output logic [DATA_WIDTH-1:0]         o_best_bid,
   output logic [DATA_WIDTH-1:0]         o_buffer_size,
   output logic [FP_WORD_SIZE-1:0]       o_buffer_size_recip,
   input  logic                          i_vol_data_valid,
   output logic                          o_vol_valid,
   output logic [SID_W-1:0]              o_vol_stock_id,
   output logic [NUM_STOCKS-1:0]         o_busy,
   output logic                          o_err_spurious,
   output logic [31:0]                   o_stall_cycles
);

   localparam int RR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(NUM_STOCKS + 1);

   logic [RR_W-1:0]         rr_ptr;
   logic [NUM_STOCKS-1:0]   busy;
   logic [SID_W-1:0]        tag_mem [NUM_STOCKS];
   logic [SID_W-1:0]        tag_wr_ptr;
   logic [SID_W-1:0]        tag_rd_ptr;
   logic [CNT_W-1:0]        tag_count;
   logic [DATA_WIDTH-1:0]   cfg_bsize [NUM_STOCKS];
   logic [FP_WORD_SIZE-1:0] cfg_recip [NUM_STOCKS];

   logic [SID_W-1:0]        req_sid [NUM_REQ];
   logic [DATA_WIDTH-1:0]   req_ask [NUM_REQ];
   logic [DATA_WIDTH-1:0]   req_bid [NUM_REQ];
   logic [NUM_REQ-1:0]      eligible;
   logic [NUM_REQ-1:0]      grant_vec;
   logic                    grant_found;
   logic [RR_W-1:0]         grant_idx;
   logic                    granted;
   logic [SID_W-1:0]        grant_sid;
   logic                    tag_nonempty;
   logic [SID_W-1:0]        tag_head;
   logic                    pop;
   logic                    cfg_accept;

   // Circular increment for tag FIFO pointers (depth need not be a power of two).
   function automatic logic [SID_W-1:0] tag_ptr_inc(input logic [SID_W-1:0] p);
      if (int'(p) == NUM_STOCKS - 1) return '0;
      else                           return p + SID_W'(1);
   endfunction

   // Circular increment for the round-robin pointer.
   function automatic logic [RR_W-1:0] rr_inc(input logic [RR_W-1:0] p);
      if (int'(p) == NUM_REQ - 1) return '0;
      else                        return p + RR_W'(1);
   endfunction

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign req_sid[g] = i_req_stock_id[g*SID_W +: SID_W];
      assign req_ask[g] = i_req_best_ask[g*DATA_WIDTH +: DATA_WIDTH];
      assign req_bid[g] = i_req_best_bid[g*DATA_WIDTH +: DATA_WIDTH];
   end

   assign tag_nonempty = (tag_count != '0);
   assign tag_head     = tag_mem[tag_rd_ptr];
   // Combinational handshakes are held low while reset is asserted.
   assign pop          = i_vol_data_valid & tag_nonempty & ~i_reset;
   assign cfg_accept   = i_cfg_wr_en & ~busy[i_cfg_stock_id] & ~i_reset;
   assign granted      = grant_found & ~i_reset;
   assign grant_sid    = req_sid[grant_idx];

   assign o_cfg_ready    = cfg_accept;
   assign o_vol_valid    = pop;
   assign o_vol_stock_id = tag_nonempty ? tag_head : '0;
   assign o_busy         = busy;
   assign o_req_ready    = grant_vec;

   // Requester eligibility: valid, stock idle, and stock not being reconfigured.
   always_comb begin
      eligible = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         eligible[i] = i_req_valid[i] & ~busy[req_sid[i]]
                       & ~(i_cfg_wr_en & (i_cfg_stock_id == req_sid[i]));
      end
   end

   // Round-robin pick: scan upward from rr_ptr; the highest k is written first so the lowest wins.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (eligible[RR_W'((int'(rr_ptr) + k) % NUM_REQ)]) begin
            grant_found = 1'b1;
            grant_idx   = RR_W'((int'(rr_ptr) + k) % NUM_REQ);
         end else begin
            grant_found = grant_found;
         end
      end
   end

   // One-hot ready vector from the selected index.
   always_comb begin
      grant_vec = '0;
      if (granted) grant_vec[grant_idx] = 1'b1;
      else         grant_vec = '0;
   end

   // Round-robin pointer advances past the granted requester.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)      rr_ptr <= '0;
      else if (granted) rr_ptr <= rr_inc(grant_idx);
      else              rr_ptr <= rr_ptr;
   end

   // In-flight lock: set on grant, cleared when that stock's result returns.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         busy <= '0;
      end else begin
         for (int s = 0; s < NUM_STOCKS; s++) begin
            if (granted && grant_sid == SID_W'(s))   busy[s] <= 1'b1;
            else if (pop && tag_head == SID_W'(s))   busy[s] <= 1'b0;
            else                                     busy[s] <= busy[s];
         end
      end
   end

   // Tag FIFO: push the granted stock, pop on completion; both may happen together.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         tag_wr_ptr <= '0;
         tag_rd_ptr <= '0;
         tag_count  <= '0;
         for (int s = 0; s < NUM_STOCKS; s++) tag_mem[s] <= '0;
      end else begin
         if (granted) begin
            tag_mem[tag_wr_ptr] <= grant_sid;
            tag_wr_ptr          <= tag_ptr_inc(tag_wr_ptr);
         end else begin
            tag_wr_ptr <= tag_wr_ptr;
         end
         if (pop) tag_rd_ptr <= tag_ptr_inc(tag_rd_ptr);
         else     tag_rd_ptr <= tag_rd_ptr;
         case ({granted, pop})
            2'b10:   tag_count <= tag_count + CNT_W'(1);
            2'b01:   tag_count <= tag_count - CNT_W'(1);
            default: tag_count <= tag_count;
         endcase
      end
   end

   // Per-stock configuration table, written only when the stock is idle.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         for (int s = 0; s < NUM_STOCKS; s++) begin
            cfg_bsize[s] <= DEFAULT_BSIZE;
            cfg_recip[s] <= DEFAULT_RECIP;
         end
      end else if (cfg_accept) begin
         cfg_bsize[i_cfg_stock_id] <= i_cfg_buffer_size;
         cfg_recip[i_cfg_stock_id] <= i_cfg_recip;
      end else begin
         cfg_bsize[i_cfg_stock_id] <= cfg_bsize[i_cfg_stock_id];
         cfg_recip[i_cfg_stock_id] <= cfg_recip[i_cfg_stock_id];
      end
   end

   // Issue register: one-cycle pulse carrying the granted update and its table entry.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_data_valid        <= 1'b0;
         o_stock_id          <= '0;
         o_best_ask          <= '0;
         o_best_bid          <= '0;
         o_buffer_size       <= '0;
         o_buffer_size_recip <= '0;
      end else if (granted) begin
         o_data_valid        <= 1'b1;
         o_stock_id          <= grant_sid;
         o_best_ask          <= req_ask[grant_idx];
         o_best_bid          <= req_bid[grant_idx];
         o_buffer_size       <= cfg_bsize[grant_sid];
         o_buffer_size_recip <= cfg_recip[grant_sid];
      end else begin
         o_data_valid        <= 1'b0;
      end
   end

   // Sticky flag for a completion arriving with no outstanding tag.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)                                o_err_spurious <= 1'b0;
      else if (i_vol_data_valid && !tag_nonempty) o_err_spurious <= 1'b1;
      else                                        o_err_spurious <= o_err_spurious;
   end

`ifdef VOL_ARB_STATS_EN
   logic [31:0] stall_cnt;

   // Saturating count of cycles where someone requested but nobody was granted.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)                                                   stall_cnt <= 32'd0;
      else if ((|i_req_valid) && !granted && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
      else                                                           stall_cnt <= stall_cnt;
   end

   assign o_stall_cycles = stall_cnt;
`else
   assign o_stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_volatility_arbiter.sv
// Self-checking bench for volatility_arbiter: directed scenarios plus random
// traffic, all compared against a queue-based reference model.
module tb_volatility_arbiter;

   logic         clk = 1'b0;
   logic         i_reset;
   logic [3:0]   i_req_valid;
   logic [3:0]   o_req_ready;
   logic [7:0]   i_req_stock_id;
   logic [127:0] i_req_best_ask, i_req_best_bid;
   logic         i_cfg_wr_en, o_cfg_ready;
   logic [1:0]   i_cfg_stock_id;
   logic [31:0]  i_cfg_buffer_size;
   logic [63:0]  i_cfg_recip;
   logic [1:0]   o_stock_id;
   logic         o_data_valid;
   logic [31:0]  o_best_ask, o_best_bid, o_buffer_size;
   logic [63:0]  o_buffer_size_recip;
   logic         i_vol_data_valid, o_vol_valid;
   logic [1:0]   o_vol_stock_id;
   logic [3:0]   o_busy;
   logic         o_err_spurious;
   logic [31:0]  o_stall_cycles;

   int checks = 0;
   int errors = 0;

   volatility_arbiter dut (
      .i_clk(clk), .i_reset(i_reset),
      .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
      .i_req_stock_id(i_req_stock_id), .i_req_best_ask(i_req_best_ask), .i_req_best_bid(i_req_best_bid),
      .i_cfg_wr_en(i_cfg_wr_en), .o_cfg_ready(o_cfg_ready), .i_cfg_stock_id(i_cfg_stock_id),
      .i_cfg_buffer_size(i_cfg_buffer_size), .i_cfg_recip(i_cfg_recip),
      .o_stock_id(o_stock_id), .o_data_valid(o_data_valid),
      .o_best_ask(o_best_ask), .o_best_bid(o_best_bid),
      .o_buffer_size(o_buffer_size), .o_buffer_size_recip(o_buffer_size_recip),
      .i_vol_data_valid(i_vol_data_valid), .o_vol_valid(o_vol_valid), .o_vol_stock_id(o_vol_stock_id),
      .o_busy(o_busy), .o_err_spurious(o_err_spurious), .o_stall_cycles(o_stall_cycles)
   );

   always #5 clk = ~clk;

   // Reference model state.
   bit          m_busy [4];
   int          m_q [$];
   int          m_rr;
   logic [31:0] m_bs [4];
   logic [63:0] m_rc [4];
   logic        m_dv, m_err;
   logic [1:0]  m_sid;
   logic [31:0] m_ask, m_bid, m_obs, m_stall;
   logic [63:0] m_orc;

   task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int s = 0; s < 4; s++) begin
         m_busy[s] = 1'b0;
         m_bs[s]   = 32'd32;
         m_rc[s]   = 64'h0000_0000_0800_0000;
      end
      m_q.delete();
      m_rr = 0; m_dv = 1'b0; m_err = 1'b0; m_sid = 2'd0;
      m_ask = 32'd0; m_bid = 32'd0; m_obs = 32'd0; m_orc = 64'd0; m_stall = 32'd0;
   endtask

   task automatic zero_inputs();
      i_req_valid = 4'd0; i_req_stock_id = 8'd0; i_req_best_ask = 128'd0; i_req_best_bid = 128'd0;
      i_cfg_wr_en = 1'b0; i_cfg_stock_id = 2'd0; i_cfg_buffer_size = 32'd0; i_cfg_recip = 64'd0;
      i_vol_data_valid = 1'b0;
   endtask

   // Assert reset with active-looking inputs; everything must read zero at once.
   task automatic do_reset();
      @(negedge clk);
      i_reset = 1'b1; i_req_valid = 4'hF; i_cfg_wr_en = 1'b1; i_vol_data_valid = 1'b1;
      #1;
      check_value("rst_req_ready", o_req_ready, 4'd0);
      check_value("rst_cfg_ready", o_cfg_ready, 1'b0);
      check_value("rst_vol_valid", o_vol_valid, 1'b0);
      check_value("rst_data_valid", o_data_valid, 1'b0);
      check_value("rst_busy", o_busy, 4'd0);
      check_value("rst_err", o_err_spurious, 1'b0);
      check_value("rst_bsize", o_buffer_size, 32'd0);
      check_value("rst_stall", o_stall_cycles, 32'd0);
      model_reset();
      @(negedge clk);
      i_reset = 1'b0;
      zero_inputs();
   endtask

   // One clock of stimulus: drive, check against the model, advance the model.
   task automatic step(input logic [3:0] v, input logic [7:0] sids, input logic [127:0] asks,
                       input logic [127:0] bids, input logic ce, input logic [1:0] cs,
                       input logic [31:0] cbs, input logic [63:0] crc, input logic vol);
      int         g;
      int         idx;
      logic [1:0] s;
      logic [3:0] exp_ready;
      logic       exp_cfg;
      @(negedge clk);
      i_req_valid = v; i_req_stock_id = sids; i_req_best_ask = asks; i_req_best_bid = bids;
      i_cfg_wr_en = ce; i_cfg_stock_id = cs; i_cfg_buffer_size = cbs; i_cfg_recip = crc;
      i_vol_data_valid = vol;
      #1;
      check_value("data_valid", o_data_valid, m_dv);
      check_value("stock_id", o_stock_id, m_sid);
      check_value("best_ask", o_best_ask, m_ask);
      check_value("best_bid", o_best_bid, m_bid);
      check_value("buffer_size", o_buffer_size, m_obs);
      check_value("recip", o_buffer_size_recip, m_orc);
      check_value("busy", o_busy, {m_busy[3], m_busy[2], m_busy[1], m_busy[0]});
      check_value("err_spurious", o_err_spurious, m_err);
      check_value("stall_cycles", o_stall_cycles, m_stall);
      g = -1;
      for (int k = 0; k < 4; k++) begin
         idx = (m_rr + k) % 4;
         s = sids[idx*2 +: 2];
         if (g < 0 && v[idx] && !m_busy[s] && !(ce && cs == s)) g = idx;
      end
      exp_ready = (g >= 0) ? 4'(1 << g) : 4'd0;
      exp_cfg   = ce && !m_busy[cs];
      check_value("req_ready", o_req_ready, exp_ready);
      check_value("cfg_ready", o_cfg_ready, exp_cfg);
      check_value("vol_valid", o_vol_valid, vol && m_q.size() > 0);
      check_value("vol_stock_id", o_vol_stock_id, (m_q.size() > 0) ? 2'(m_q[0]) : 2'd0);
      if (vol) begin
         if (m_q.size() > 0) begin
            m_busy[m_q[0]] = 1'b0;
            void'(m_q.pop_front());
         end else begin
            m_err = 1'b1;
         end
      end
      if (g >= 0) begin
         s = sids[g*2 +: 2];
         m_dv = 1'b1; m_sid = s;
         m_ask = asks[g*32 +: 32]; m_bid = bids[g*32 +: 32];
         m_obs = m_bs[s]; m_orc = m_rc[s];
         m_busy[s] = 1'b1;
         m_q.push_back(int'(s));
         m_rr = (g + 1) % 4;
      end else begin
         m_dv = 1'b0;
      end
      if (exp_cfg) begin
         m_bs[cs] = cbs;
         m_rc[cs] = crc;
      end
`ifdef VOL_ARB_STATS_EN
      if ((|v) && g < 0 && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
`endif
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic idle();
      step(4'd0, 8'd0, 128'd0, 128'd0, 1'b0, 2'd0, 32'd0, 64'd0, 1'b0);
   endtask

   logic [3:0] t1_exp [5];

   initial begin
      i_reset = 1'b1;
      zero_inputs();
      model_reset();
      do_reset();

      // Scenario 1: four requesters on stocks 0..3, completions after each issue.
      t1_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      for (int c = 0; c < 5; c++) begin
         step(4'hF, 8'b11_10_01_00, rnd128(), rnd128(), 1'b0, 2'd0, 32'd0, 64'd0, c > 0);
         check_value("t1_grant", o_req_ready, t1_exp[c]);
         if (c > 0) begin
            check_value("t1_bsize", o_buffer_size, 32'd32);
            check_value("t1_recip", o_buffer_size_recip, 64'h0800_0000);
         end
      end

      // Scenario 2: two requesters on the same stock.
      do_reset();
      step(4'b0011, 8'b00_00_10_10, rnd128(), rnd128(), 1'b0, 2'd0, 32'd0, 64'd0, 1'b0);
      check_value("t2_first", o_req_ready, 4'b0001);
      step(4'b0011, 8'b00_00_10_10, rnd128(), rnd128(), 1'b0, 2'd0, 32'd0, 64'd0, 1'b0);
      check_value("t2_locked", o_req_ready, 4'b0000);
      step(4'b0010, 8'b00_00_10_10, rnd128(), rnd128(), 1'b0, 2'd0, 32'd0, 64'd0, 1'b1);
      check_value("t2_tag", o_vol_stock_id, 2'd2);
      check_value("t2_still_locked", o_req_ready, 4'b0000);
      step(4'b0010, 8'b00_00_10_10, rnd128(), rnd128(), 1'b0, 2'd0, 32'd0, 64'd0, 1'b0);
      check_value("t2_second", o_req_ready, 4'b0010);

      // Scenario 3: config write to a busy stock stalls until completion.
      do_reset();
      step(4'b0001, 8'b00_00_00_01, rnd128(), rnd128(), 1'b0, 2'd0, 32'd0, 64'd0, 1'b0);
      for (int c = 0; c < 3; c++) begin
         step(4'd0, 8'd0, 128'd0, 128'd0, 1'b1, 2'd1, 32'd16, 64'h1000_0000, c == 2);
         check_value("t3_cfg_blocked", o_cfg_ready, 1'b0);
      end
      step(4'd0, 8'd0, 128'd0, 128'd0, 1'b1, 2'd1, 32'd16, 64'h1000_0000, 1'b0);
      check_value("t3_cfg_accept", o_cfg_ready, 1'b1);
      step(4'b0001, 8'b00_00_00_01, rnd128(), rnd128(), 1'b0, 2'd0, 32'd0, 64'd0, 1'b0);
      idle();
      check_value("t3_bsize", o_buffer_size, 32'd16);
      check_value("t3_recip", o_buffer_size_recip, 64'h1000_0000);

      // Scenario 4: issue stocks 3,0,1 and return them in order.
      do_reset();
      for (int c = 0; c < 3; c++)
         step(4'b0111, 8'b00_01_00_11, rnd128(), rnd128(), 1'b0, 2'd0, 32'd0, 64'd0, 1'b0);
      step(4'd0, 8'd0, 128'd0, 128'd0, 1'b0, 2'd0, 32'd0, 64'd0, 1'b1);
      check_value("t4_tag0", o_vol_stock_id, 2'd3);
      step(4'd0, 8'd0, 128'd0, 128'd0, 1'b0, 2'd0, 32'd0, 64'd0, 1'b1);
      check_value("t4_tag1", o_vol_stock_id, 2'd0);
      step(4'd0, 8'd0, 128'd0, 128'd0, 1'b0, 2'd0, 32'd0, 64'd0, 1'b1);
      check_value("t4_tag2", o_vol_stock_id, 2'd1);
      idle();
      check_value("t4_busy_clear", o_busy, 4'd0);

      // Scenario 5: spurious completion is sticky.
      step(4'd0, 8'd0, 128'd0, 128'd0, 1'b0, 2'd0, 32'd0, 64'd0, 1'b1);
      idle(); idle(); idle();
      check_value("t5_err_sticky", o_err_spurious, 1'b1);

      // Scenario 6: requester held on a busy stock for ten cycles.
      do_reset();
      step(4'b0001, 8'd0, rnd128(), rnd128(), 1'b0, 2'd0, 32'd0, 64'd0, 1'b0);
      for (int c = 0; c < 10; c++)
         step(4'b0001, 8'd0, rnd128(), rnd128(), 1'b0, 2'd0, 32'd0, 64'd0, 1'b0);
      idle();
`ifdef VOL_ARB_STATS_EN
      check_value("t6_stall", o_stall_cycles, 32'd10);
`else
      check_value("t6_stall", o_stall_cycles, 32'd0);
`endif

      // Random traffic with a reset in the middle.
      do_reset();
      for (int c = 0; c < 400; c++) begin
         if (c == 200) do_reset();
         step(4'($urandom), 8'($urandom), rnd128(), rnd128(),
              ($urandom % 4) == 0, 2'($urandom), $urandom, {$urandom, $urandom},
              ($urandom % 3) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
